ucq_arb: RTL and testbench
==========================

Name: ucq_arb

Overview:
- Unit-clause queue and arbiter that sits directly upstream of the NUM_PE bcp_pe engines.
- Captures one-cycle implication pulses from every PE and serialises them round-robin into a unit-clause FIFO (UCQ). Injects decision literals into the same FIFO.
- Broadcasts the FIFO head literal to every PE exactly once, and pops it only after all PEs have taken it.
- Detects contradictory units and combines PE conflict pulses into one sticky conflict flag.

Parameters:
- NUM_PE, 4, number of bcp_pe engines served.
- UCQ_DEPTH, 16, UCQ entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-HIGH reset (asserted = 1, sampled on posedge clk).
- pe_imply_valid  in  NUM_PE  per-PE imply_valid.
- pe_imply_lit  in  NUM_PE x lit_t  per-PE imply_lit.
- pe_conflict  in  NUM_PE  per-PE conflict.
- pe_newLitAccept  in  NUM_PE  per-PE bcp2ucarb_newLitAccept.
- ucarb2bcp_newLit  out  lit_t  UCQ head literal, broadcast to all PEs.
- ucarb2bcp_newLitValid  out  NUM_PE  per-PE valid.
- halt  out  1  stall to all PEs.
- dec_valid  in  1  decision literal offered.
- dec_lit  in  lit_t  decision literal (nonzero, signed).
- dec_ready  out  1  decision accepted this cycle when dec_valid && dec_ready.
- conflict  out  1  sticky conflict.
- ucq_empty  out  1  UCQ and all capture slots empty.

Behaviour:
Reset values:
- All capture slots are empty, the FIFO is empty, the taken mask is 0 and the round-robin pointer is 0.
- conflict=0, halt=0, all newLitValid=0, newLit=0, dec_ready=0 during reset, ucq_empty=1.

Capture slots (one per PE, registered):
- The slot loads when pe_imply_valid[i] && pe_imply_lit[i]!=0 && the slot is empty.
- halt = any slot full || conflict. This is registered-derived, so a PE that implies in cycle t is halted from t+1. A halted PE emits no implication.
- A pulse arriving while the slot is full is a protocol error: assertion only, and the pulse is dropped.

Drain:
- Each cycle at most one full slot, chosen round-robin starting at the pointer, is considered. It is removed only if the FIFO is not full.
- On removal the pointer moves to the granted index +1, mod NUM_PE.
- The drained literal L is compared against every valid FIFO entry:
  - If L is present, the slot is cleared and nothing is pushed (dedup).
  - If -L is present, conflict is set and nothing is pushed.
  - Otherwise L is pushed.
- When the FIFO is full, slots hold and halt stays high.

Decision push:
- dec_ready = !conflict && all slots empty && FIFO not full && no drain this cycle.
- An accepted decision goes through the same dedup/contradiction check.
- Slot drain always has priority over a decision.

Broadcast:
- newLit = FIFO head.
- newLitValid[i] = !empty && !taken[i] && !conflict.
- taken[i] is set when newLitValid[i] && pe_newLitAccept[i] && !halt.
- When (taken | the new takes) == all ones, the head pops in that same cycle and taken clears to 0.
- A push and a pop in the same cycle are legal at any occupancy except: when full, a pop permits the push in the same cycle. Pointer wrap is mod UCQ_DEPTH.

Conflict:
- Set by any pe_conflict bit, or by the contradiction check.
- Sticky until reset.
- On the set cycle the FIFO, slots and taken mask are flushed in the next cycle.
- After that, halt=1 and dec_ready=0 until reset.

Other rules:
- ucq_empty is combinational from registered state.
- Reset mid-operation discards all state within one cycle.

Decomposition:
- Shared package (existing project package):
  - lit_t (signed, 0 reserved).
  - Literal-negate function.
  - NUM_PE and UCQ_DEPTH defaults.
- Sub-module ucq_fifo: circular buffer with head/tail/count, and a parallel match port that returns hit_same and hit_neg for a query literal.
- ucq_arb holds the slots, round-robin arbitration, taken mask and conflict logic.

Test Plan:
1. Reset, then dec_lit=+5 -> the next cycle newLit=+5 and newLitValid=4'b1111. PEs accept in cycles 3, 4, 4, 6 -> pop occurs in cycle 6 and ucq_empty=1 in cycle 7.
2. PE0 and PE2 imply +3 and -7 in the same cycle -> halt=1 the next cycle. FIFO receives +3 then -7 on consecutive cycles (pointer 0). halt drops after both drain.
3. PE1 implies +9 while +9 is already queued -> no push, FIFO count is unchanged.
4. PE3 implies -4 while +4 is queued -> conflict=1 the next cycle. The FIFO is flushed, newLitValid=0, dec_ready=0, and all of this persists until rst_n=1.
5. Fill the FIFO to 16 entries, then PE0 implies +20 -> the slot holds with halt=1. One full pop occurs -> +20 is pushed in the pop cycle.
6. Assert rst_n=1 mid-broadcast with taken=4'b0101 -> the next cycle all outputs hold their reset values and the FIFO is empty.

Source files
------------

// File: rtl/ucq_arb_pkg.sv
// Shared literal types and defaults for the unit-clause queue and arbiter.
package ucq_arb_pkg;

  localparam int unsigned LIT_W         = 16;
  localparam int unsigned NUM_PE_DEF    = 4;
  localparam int unsigned UCQ_DEPTH_DEF = 16;

  // Signed literal; 0 is reserved as "no literal".
  typedef logic signed [LIT_W-1:0] lit_t;

  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/ucq_fifo.sv
// Circular unit-clause FIFO with a parallel same/negated match against all live entries.
module ucq_fifo
  import ucq_arb_pkg::*;
#(
  parameter int unsigned DEPTH = UCQ_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  lit_t push_lit,
  input  logic pop,
  output lit_t head_lit,
  output logic empty,
  output logic full,
  input  lit_t query_lit,
  output logic hit_same,
  output logic hit_neg
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  lit_t              mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;
  lit_t              query_neg;
  logic [ADDR_W-1:0] off;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  // A pop frees the slot the simultaneous push needs when full.
  assign do_push   = push && (!full || do_pop);
  assign head_lit  = empty ? '0 : mem[head];
  assign query_neg = lit_neg(query_lit);

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_lit;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + ADDR_W'(1);
      if (do_pop)  head <= head + ADDR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    hit_same = 1'b0;
    hit_neg  = 1'b0;
    off      = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off = ADDR_W'(j) - head;
      if (CNT_W'(off) < count) begin
        if (mem[j] == query_lit) hit_same = 1'b1;
        if (mem[j] == query_neg) hit_neg  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ucq_arb.sv
// Captures PE implications into per-PE slots, serialises them round-robin into the
// unit-clause FIFO with decisions, broadcasts the head once to every PE, tracks conflict.
module ucq_arb
  import ucq_arb_pkg::*;
#(
  parameter int unsigned NUM_PE    = NUM_PE_DEF,
  parameter int unsigned UCQ_DEPTH = UCQ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] pe_imply_valid,
  input  lit_t              pe_imply_lit [NUM_PE],
  input  logic [NUM_PE-1:0] pe_conflict,
  input  logic [NUM_PE-1:0] pe_newLitAccept,
  output lit_t              ucarb2bcp_newLit,
  output logic [NUM_PE-1:0] ucarb2bcp_newLitValid,
  output logic              halt,
  input  logic              dec_valid,
  input  lit_t              dec_lit,
  output logic              dec_ready,
  output logic              conflict,
  output logic              ucq_empty
);

  localparam int unsigned PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [NUM_PE-1:0]   slot_full;
  lit_t                slot_lit [NUM_PE];
  logic [NUM_PE-1:0]   load;
  logic [PE_IDX_W-1:0] rr_ptr;
  logic [PE_IDX_W-1:0] ptr_next;
  logic [PE_IDX_W-1:0] gnt_idx;
  logic                gnt_found;
  logic [NUM_PE-1:0]   taken;
  logic [NUM_PE-1:0]   takes;
  logic                take_en;
  logic                fifo_empty;
  logic                fifo_full;
  logic                hit_same;
  logic                hit_neg;
  logic                pop;
  logic                drain;
  logic                dec_fire;
  logic                cand;
  logic                contra;
  logic                push;
  logic                conflict_set;
  logic                flush;
  lit_t                q_lit;

  function automatic logic [PE_IDX_W-1:0] rr_idx(input logic [PE_IDX_W-1:0] p,
                                                 input int unsigned k);
    return PE_IDX_W'((32'(p) + k) % NUM_PE);
  endfunction

  ucq_fifo #(.DEPTH(UCQ_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst_n),
    .flush    (flush),
    .push     (push),
    .push_lit (q_lit),
    .pop      (pop),
    .head_lit (ucarb2bcp_newLit),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .query_lit(q_lit),
    .hit_same (hit_same),
    .hit_neg  (hit_neg)
  );

  // First full slot at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      if (!gnt_found && slot_full[rr_idx(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      load[i] = pe_imply_valid[i] && (pe_imply_lit[i] != '0) && !slot_full[i];
    end
  end

  assign ptr_next = (gnt_idx == PE_IDX_W'(NUM_PE - 1)) ? '0 : gnt_idx + PE_IDX_W'(1);

  assign halt                  = (|slot_full) || conflict;
  assign ucq_empty             = fifo_empty && !(|slot_full);
  assign ucarb2bcp_newLitValid = {NUM_PE{!fifo_empty && !conflict}} & ~taken;

  // Pending slots normally freeze takes; with a full FIFO only a pop can
  // drain them, so takes must keep flowing to avoid a deadlock.
  assign take_en = !(|slot_full) || fifo_full;
  assign takes   = ucarb2bcp_newLitValid & pe_newLitAccept & {NUM_PE{take_en}};
  assign pop     = !fifo_empty && !conflict && (&(taken | takes));

  assign drain     = gnt_found && !conflict && (!fifo_full || pop);
  assign dec_ready = !rst_n && !conflict && !(|slot_full) && !fifo_full && !drain;
  assign dec_fire  = dec_valid && dec_ready && (dec_lit != '0);

  assign cand         = drain || dec_fire;
  assign q_lit        = drain ? slot_lit[gnt_idx] : dec_lit;
  assign contra       = cand && hit_neg;
  assign push         = cand && !hit_same && !hit_neg;
  assign conflict_set = (|pe_conflict) || contra;
  assign flush        = conflict || conflict_set;

  always_ff @(posedge clk) begin
    if (rst_n || flush) begin
      slot_full <= '0;
      for (int unsigned i = 0; i < NUM_PE; i++) slot_lit[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (drain && gnt_idx == PE_IDX_W'(i)) slot_full[i] <= 1'b0;
        if (load[i]) begin
          slot_full[i] <= 1'b1;
          slot_lit[i]  <= pe_imply_lit[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)      rr_ptr <= '0;
    else if (drain) rr_ptr <= ptr_next;
  end

  always_ff @(posedge clk) begin
    if (rst_n || flush) taken <= '0;
    else if (pop)       taken <= '0;
    else                taken <= taken | takes;
  end

  always_ff @(posedge clk) begin
    if (rst_n)             conflict <= 1'b0;
    else if (conflict_set) conflict <= 1'b1;
  end

  // A halted PE must not pulse into a slot it already owns.
  assert property (@(posedge clk) disable iff (rst_n) (pe_imply_valid & slot_full) == '0);

endmodule

// File: tb/tb_ucq_arb.sv
// Directed bench for ucq_arb: table of per-cycle vectors plus hand-written corner sequences.
module tb_ucq_arb;
  import ucq_arb_pkg::*;

  localparam int unsigned NPE = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NPE-1:0] pe_imply_valid;
  lit_t           pe_imply_lit [NPE];
  logic [NPE-1:0] pe_conflict;
  logic [NPE-1:0] pe_newLitAccept;
  lit_t           ucarb2bcp_newLit;
  logic [NPE-1:0] ucarb2bcp_newLitValid;
  logic           halt;
  logic           dec_valid;
  lit_t           dec_lit;
  logic           dec_ready;
  logic           conflict;
  logic           ucq_empty;

  ucq_arb #(.NUM_PE(NPE), .UCQ_DEPTH(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pe_imply_valid       (pe_imply_valid),
    .pe_imply_lit         (pe_imply_lit),
    .pe_conflict          (pe_conflict),
    .pe_newLitAccept      (pe_newLitAccept),
    .ucarb2bcp_newLit     (ucarb2bcp_newLit),
    .ucarb2bcp_newLitValid(ucarb2bcp_newLitValid),
    .halt                 (halt),
    .dec_valid            (dec_valid),
    .dec_lit              (dec_lit),
    .dec_ready            (dec_ready),
    .conflict             (conflict),
    .ucq_empty            (ucq_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] iv;
    lit_t       l0;
    lit_t       l2;
    logic [3:0] acc;
    logic       dv;
    lit_t       dl;
    lit_t       e_lit;
    logic [3:0] e_val;
    logic       e_halt;
    logic       e_dr;
    logic       e_cf;
    logic       e_empty;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] iv, input lit_t l0, input lit_t l1, input lit_t l2,
                        input lit_t l3, input logic [3:0] cf, input logic [3:0] acc,
                        input logic dv, input lit_t dl);
    pe_imply_valid  = iv;
    pe_imply_lit[0] = l0;
    pe_imply_lit[1] = l1;
    pe_imply_lit[2] = l2;
    pe_imply_lit[3] = l3;
    pe_conflict     = cf;
    pe_newLitAccept = acc;
    dec_valid       = dv;
    dec_lit         = dl;
  endtask

  task automatic idle();
    set_in('0, '0, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic dec(input lit_t l);
    set_in('0, '0, '0, '0, '0, '0, '0, 1'b1, l);
  endtask

  task automatic accept(input logic [3:0] acc);
    set_in('0, '0, '0, '0, '0, '0, acc, 1'b0, '0);
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] iv, input lit_t l0,
                              input lit_t l2, input logic [3:0] acc, input logic dv,
                              input lit_t dl, input lit_t e_lit, input logic [3:0] e_val,
                              input logic e_halt, input logic e_dr, input logic e_cf,
                              input logic e_empty);
    vec_t v;
    v.rst = rst; v.iv = iv; v.l0 = l0; v.l2 = l2; v.acc = acc; v.dv = dv; v.dl = dl;
    v.e_lit = e_lit; v.e_val = e_val; v.e_halt = e_halt; v.e_dr = e_dr;
    v.e_cf = e_cf; v.e_empty = e_empty;
    return v;
  endfunction

  initial begin
    idle();

    // Reset, decision +5 broadcast with staggered accepts, then two same-cycle implications.
    vecs[0]  = mk(1, 4'h0, 0, 0, 4'h0, 0, 0,      0,  4'h0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 4'h0, 0, 0, 4'h0, 1, 16'sd5, 16'sd5, 4'hF, 0, 1, 0, 0);
    vecs[2]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,      16'sd5, 4'hF, 0, 1, 0, 0);
    vecs[3]  = mk(0, 4'h0, 0, 0, 4'h1, 0, 0,      16'sd5, 4'hE, 0, 1, 0, 0);
    vecs[4]  = mk(0, 4'h0, 0, 0, 4'h6, 0, 0,      16'sd5, 4'h8, 0, 1, 0, 0);
    vecs[5]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,      16'sd5, 4'h8, 0, 1, 0, 0);
    vecs[6]  = mk(0, 4'h0, 0, 0, 4'h8, 0, 0,      0,      4'h0, 0, 1, 0, 1);
    vecs[7]  = mk(0, 4'h5, 16'sd3, -16'sd7, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,      16'sd3, 4'hF, 1, 0, 0, 0);
    vecs[9]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0,      16'sd3, 4'hF, 0, 1, 0, 0);
    vecs[10] = mk(0, 4'h0, 0, 0, 4'hF, 0, 0,      -16'sd7, 4'hF, 0, 1, 0, 0);
    vecs[11] = mk(0, 4'h0, 0, 0, 4'hF, 0, 0,      0,      4'h0, 0, 1, 0, 1);

    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].rst;
      set_in(vecs[i].iv, vecs[i].l0, '0, vecs[i].l2, '0, '0, vecs[i].acc, vecs[i].dv, vecs[i].dl);
      tick();
      chk($sformatf("vec%0d", i),
          64'({ucarb2bcp_newLit, ucarb2bcp_newLitValid, halt, dec_ready, conflict, ucq_empty}),
          64'({vecs[i].e_lit, vecs[i].e_val, vecs[i].e_halt, vecs[i].e_dr, vecs[i].e_cf,
               vecs[i].e_empty}));
    end

    // Duplicate implication is dropped without changing the queue.
    dec(16'sd9); tick();
    chk("t3_count_push", 64'(dut.u_fifo.count), 64'(1));
    set_in(4'h2, '0, 16'sd9, '0, '0, '0, '0, 1'b0, '0); tick();
    chk("t3_halt", 64'(halt), 64'(1));
    idle(); tick();
    chk("t3_count_dedup", 64'(dut.u_fifo.count), 64'(1));
    chk("t3_halt_drop", 64'(halt), 64'(0));
    chk("t3_head", 64'(ucarb2bcp_newLit), 64'(16'sd9));
    accept(4'hF); tick();
    chk("t3_empty", 64'(ucq_empty), 64'(1));

    // Contradiction against a queued literal sets sticky conflict and flushes.
    dec(16'sd4); tick();
    set_in(4'h8, '0, '0, '0, -16'sd4, '0, '0, 1'b0, '0); tick();
    chk("t4_pre_conflict", 64'(conflict), 64'(0));
    idle(); tick();
    chk("t4_conflict", 64'(conflict), 64'(1));
    chk("t4_count", 64'(dut.u_fifo.count), 64'(0));
    chk("t4_outs", 64'({ucarb2bcp_newLitValid, dec_ready, halt, ucq_empty}), 64'(6'b0000_0_1_1));
    for (int i = 0; i < 3; i++) begin
      set_in('0, '0, '0, '0, '0, '0, 4'hF, 1'b1, 16'sd8); tick();
      chk($sformatf("t4_sticky%0d", i),
          64'({conflict, halt, dec_ready, ucarb2bcp_newLitValid, dut.u_fifo.count}),
          64'({1'b1, 1'b1, 1'b0, 4'h0, 5'd0}));
    end
    rst_n = 1'b1; idle(); tick();
    chk("t4_reset", 64'({conflict, halt, dec_ready, ucq_empty}), 64'(4'b0001));
    rst_n = 1'b0; #1;
    chk("t4_ready_after_reset", 64'(dec_ready), 64'(1));

    // Fill the queue, then a pending implication enters only on the pop cycle.
    for (int i = 0; i < 16; i++) begin
      dec(lit_t'(i + 1)); tick();
    end
    chk("t5_full", 64'({dut.u_fifo.count, dec_ready}), 64'({5'd16, 1'b0}));
    set_in(4'h1, 16'sd20, '0, '0, '0, '0, '0, 1'b0, '0); tick();
    idle(); tick(); tick();
    chk("t5_hold", 64'({halt, dut.u_fifo.count}), 64'({1'b1, 5'd16}));
    chk("t5_head1", 64'(ucarb2bcp_newLit), 64'(16'sd1));
    accept(4'hF); tick();
    chk("t5_poppush", 64'({halt, dut.u_fifo.count}), 64'({1'b0, 5'd16}));
    chk("t5_head2", 64'(ucarb2bcp_newLit), 64'(16'sd2));
    for (int i = 0; i < 15; i++) tick();
    chk("t5_tail", 64'(ucarb2bcp_newLit), 64'(16'sd20));
    chk("t5_tail_count", 64'(dut.u_fifo.count), 64'(1));
    tick();
    chk("t5_drained", 64'(ucq_empty), 64'(1));

    // Reset in the middle of a partial broadcast.
    dec(16'sd6); tick();
    chk("t6_bcast", 64'(ucarb2bcp_newLitValid), 64'(4'hF));
    accept(4'h5); tick();
    chk("t6_taken", 64'(ucarb2bcp_newLitValid), 64'(4'hA));
    rst_n = 1'b1; idle(); tick();
    chk("t6_reset_outs",
        64'({ucarb2bcp_newLit, ucarb2bcp_newLitValid, halt, dec_ready, conflict, ucq_empty}),
        64'({16'sd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
    chk("t6_reset_count", 64'(dut.u_fifo.count), 64'(0));
    rst_n = 1'b0; dec(16'sd6); tick();
    chk("t6_taken_cleared", 64'(ucarb2bcp_newLitValid), 64'(4'hF));

    // A PE conflict pulse alone sets the sticky flag.
    set_in('0, '0, '0, '0, '0, 4'h2, '0, 1'b0, '0); tick();
    idle();
    chk("t7_pe_conflict", 64'({conflict, halt, ucarb2bcp_newLitValid}), 64'({1'b1, 1'b1, 4'h0}));
    tick();
    chk("t7_flushed", 64'({conflict, ucq_empty, dut.u_fifo.count}), 64'({1'b1, 1'b1, 5'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
